// File: rtl/core_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// core_pipe_ctrl
//   Pipeline sequencer for the 5-stage core. Produces per-stage enable/kill for
//   the IF, DEC, EXE and MEM stage registers from the load-use hazard check,
//   the L1I/L1D handshakes and taken branches. It also keeps a saturating
//   stall-cycle counter and a sticky L1D timeout flag.
//
// Ports
//   clk, rst_n                  core clock, async active-low reset
//   dec_val_in/rs1/rs2/haz_cmd  decode-stage operand info (cmd: bit0 rs1, bit1 rs2)
//   exe_rd/we/load/br_taken     execute-stage destination and branch resolution
//   mem_l1d_val/ack             MEM-stage L1D request handshake
//   if_l1i_ack                  L1I fetch delivered
//   *_enb_out / *_kill_out      stage register update / bubble insert
//   stall_cnt_out               cycles with if_enb_out=0, saturating
//   err_dtimeout_out            sticky: an L1D wait reached DWAIT_MAX cycles
// ----------------------------------------------------------------------------
module core_pipe_ctrl #(
    parameter int CNT_W     = 16,
    parameter int DWAIT_MAX = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_val_in,
    input  logic [4:0]       dec_rs1_in,
    input  logic [4:0]       dec_rs2_in,
    input  logic [1:0]       dec_haz_cmd_in,
    input  logic [4:0]       exe_rd_in,
    input  logic             exe_we_in,
    input  logic             exe_load_in,
    input  logic             exe_br_taken_in,
    input  logic             mem_l1d_val_in,
    input  logic             mem_l1d_ack_in,
    input  logic             if_l1i_ack_in,
    output logic             if_enb_out,
    output logic             dec_enb_out,
    output logic             dec_kill_out,
    output logic             exe_enb_out,
    output logic             exe_kill_out,
    output logic             mem_enb_out,
    output logic [CNT_W-1:0] stall_cnt_out,
    output logic             err_dtimeout_out
);

    localparam int WC_W = $clog2(DWAIT_MAX + 1);

    typedef enum logic [1:0] {ST_RUN, ST_DWAIT, ST_IWAIT} state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_q;
    logic              hz, d_miss, i_miss;

    assign hz = dec_val_in && exe_load_in && exe_we_in && (exe_rd_in != 5'd0) &&
                ((dec_haz_cmd_in[0] && (dec_rs1_in == exe_rd_in)) ||
                 (dec_haz_cmd_in[1] && (dec_rs2_in == exe_rd_in)));

    // Once frozen on a D-miss, only the ack releases the pipe, even if the
    // request valid drops meanwhile.
    assign d_miss = (state_q == ST_DWAIT) ? !mem_l1d_ack_in
                                          : (mem_l1d_val_in && !mem_l1d_ack_in);
    assign i_miss = !if_l1i_ack_in;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = ST_RUN;
        if (d_miss)                          state_d = ST_DWAIT;
        else if (exe_br_taken_in || hz)      state_d = ST_RUN;
        else if (i_miss)                     state_d = ST_IWAIT;
    end

    // ---------------- outputs ----------------
    always_comb begin
        if_enb_out   = 1'b1;
        dec_enb_out  = 1'b1;
        dec_kill_out = 1'b0;
        exe_enb_out  = 1'b1;
        exe_kill_out = 1'b0;
        mem_enb_out  = 1'b1;
        if (!rst_n) begin
            if_enb_out   = 1'b0;
            dec_enb_out  = 1'b0;
            dec_kill_out = 1'b1;
            exe_enb_out  = 1'b0;
            exe_kill_out = 1'b1;
            mem_enb_out  = 1'b0;
        end else if (d_miss) begin
            if_enb_out   = 1'b0;
            dec_enb_out  = 1'b0;
            exe_enb_out  = 1'b0;
            mem_enb_out  = 1'b0;
        end else if (exe_br_taken_in) begin
            // flush the two wrong-path instructions; a pending hazard is moot
            dec_kill_out = 1'b1;
            exe_kill_out = 1'b1;
        end else if (hz) begin
            // hold IF/DEC, push a bubble into EXE, let the load proceed
            if_enb_out   = 1'b0;
            dec_enb_out  = 1'b0;
            exe_kill_out = 1'b1;
        end else if (i_miss) begin
            if_enb_out   = 1'b0;
            dec_kill_out = 1'b1;
        end
    end

    // ---------------- L1D wait counter / timeout ----------------
    // wait_q counts completed stalled cycles; err latches on the edge where
    // the count reaches DWAIT_MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q           <= '0;
            err_dtimeout_out <= 1'b0;
        end else if (d_miss) begin
            if (wait_q != WC_W'(DWAIT_MAX)) wait_q <= wait_q + WC_W'(1);
            if (wait_q >= WC_W'(DWAIT_MAX - 1)) err_dtimeout_out <= 1'b1;
        end else begin
            wait_q <= '0;
        end
    end

    // ---------------- stall counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_out <= '0;
        else if (!if_enb_out && (stall_cnt_out != {CNT_W{1'b1}}))
            stall_cnt_out <= stall_cnt_out + CNT_W'(1);
    end

endmodule

// File: tb/tb_core_pipe_ctrl.sv
module tb_core_pipe_ctrl;

    localparam int CNT_W = 4;
    localparam int DWAIT_MAX = 4;

    // {if_enb, dec_enb, dec_kill, exe_enb, exe_kill, mem_enb}
    localparam logic [5:0] O_RST = 6'b001010;
    localparam logic [5:0] O_RUN = 6'b110101;
    localparam logic [5:0] O_DMS = 6'b000000;
    localparam logic [5:0] O_BR  = 6'b111111;
    localparam logic [5:0] O_LU  = 6'b000111;
    localparam logic [5:0] O_IMS = 6'b011101;

    logic clk = 1'b0;
    logic rst_n;
    logic dec_val, exe_we, exe_load, br_taken, l1d_val, l1d_ack, l1i_ack;
    logic [4:0] rs1, rs2, exe_rd;
    logic [1:0] cmd;
    logic if_enb, dec_enb, dec_kill, exe_enb, exe_kill, mem_enb, err;
    logic [CNT_W-1:0] stall_cnt;
    logic [5:0] outs;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign outs = {if_enb, dec_enb, dec_kill, exe_enb, exe_kill, mem_enb};

    core_pipe_ctrl #(.CNT_W(CNT_W), .DWAIT_MAX(DWAIT_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .dec_val_in(dec_val), .dec_rs1_in(rs1), .dec_rs2_in(rs2), .dec_haz_cmd_in(cmd),
        .exe_rd_in(exe_rd), .exe_we_in(exe_we), .exe_load_in(exe_load),
        .exe_br_taken_in(br_taken),
        .mem_l1d_val_in(l1d_val), .mem_l1d_ack_in(l1d_ack), .if_l1i_ack_in(l1i_ack),
        .if_enb_out(if_enb), .dec_enb_out(dec_enb), .dec_kill_out(dec_kill),
        .exe_enb_out(exe_enb), .exe_kill_out(exe_kill), .mem_enb_out(mem_enb),
        .stall_cnt_out(stall_cnt), .err_dtimeout_out(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock, land 1 time unit past the edge
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        dec_val = 0; rs1 = 0; rs2 = 0; cmd = 2'b00;
        exe_rd = 0; exe_we = 0; exe_load = 0; br_taken = 0;
        l1d_val = 0; l1d_ack = 0; l1i_ack = 1;
        nxt(); nxt();
        chk("rst_outs", 32'(outs), 32'(O_RST));
        chk("rst_cnt", 32'(stall_cnt), 0);
        chk("rst_err", 32'(err), 0);

        rst_n = 1'b1; #1;
        chk("idle_run", 32'(outs), 32'(O_RUN));

        // lw x5 ; add x6,x5,x1 (cmd=01)
        dec_val = 1; rs1 = 5; rs2 = 1; cmd = 2'b01;
        exe_rd = 5; exe_we = 1; exe_load = 1; #1;
        chk("lu_rs1", 32'(outs), 32'(O_LU));
        nxt();
        chk("lu_cnt", 32'(stall_cnt), 1);

        exe_rd = 0; rs1 = 0; #1;
        chk("rd0_nostall", 32'(outs), 32'(O_RUN));
        exe_rd = 5; rs1 = 5; rs2 = 3; cmd = 2'b10; #1;
        chk("cmd10_nostall", 32'(outs), 32'(O_RUN));
        rs2 = 5; cmd = 2'b00; #1;
        chk("cmd00_nostall", 32'(outs), 32'(O_RUN));
        rs1 = 3; cmd = 2'b11; #1;
        chk("lu_rs2", 32'(outs), 32'(O_LU));
        nxt();
        chk("lu2_cnt", 32'(stall_cnt), 2);

        // taken branch wins over the hazard
        br_taken = 1; #1;
        chk("br_hz", 32'(outs), 32'(O_BR));
        nxt();
        chk("br_cnt", 32'(stall_cnt), 2);
        br_taken = 0; dec_val = 0; exe_load = 0; #1;

        // I-miss for two cycles
        l1i_ack = 0; #1;
        chk("imiss1", 32'(outs), 32'(O_IMS));
        nxt();
        chk("imiss2", 32'(outs), 32'(O_IMS));
        nxt();
        l1i_ack = 1; #1;
        chk("imiss_done", 32'(outs), 32'(O_RUN));
        chk("imiss_cnt", 32'(stall_cnt), 4);

        // D-miss, ack withheld 3 cycles; branch cannot preempt
        l1d_val = 1; l1d_ack = 0; br_taken = 1; #1;
        chk("dmiss_br", 32'(outs), 32'(O_DMS));
        br_taken = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("dmiss_frz", 32'(outs), 32'(O_DMS));
            nxt();
        end
        chk("dmiss_err0", 32'(err), 0);
        l1d_ack = 1; #1;
        chk("dack_run", 32'(outs), 32'(O_RUN));
        nxt();
        chk("dmiss_cnt", 32'(stall_cnt), 7);
        l1d_val = 0; l1d_ack = 0;

        // timeout: 6 stalled cycles with DWAIT_MAX=4
        l1d_val = 1; #1;
        nxt(); nxt(); nxt();
        chk("to_err_3", 32'(err), 0);
        nxt();
        chk("to_err_4", 32'(err), 1);
        nxt(); nxt();
        chk("to_frz_6", 32'(outs), 32'(O_DMS));
        l1d_val = 0; #1;
        chk("dwait_holds", 32'(outs), 32'(O_DMS));
        l1d_ack = 1; #1;
        chk("to_ack", 32'(outs), 32'(O_RUN));
        nxt();
        l1d_ack = 0;
        chk("to_sticky", 32'(err), 1);
        chk("to_cnt", 32'(stall_cnt), 13);

        // stall counter saturation (4 bits)
        l1i_ack = 0;
        repeat (5) nxt();
        l1i_ack = 1;
        chk("cnt_sat", 32'(stall_cnt), 15);

        // reset in the middle of a D-miss wait
        l1d_val = 1; l1d_ack = 0;
        repeat (5) nxt();
        rst_n = 1'b0; #1;
        chk("mrst_outs", 32'(outs), 32'(O_RST));
        chk("mrst_cnt", 32'(stall_cnt), 0);
        chk("mrst_err", 32'(err), 0);
        l1d_val = 0;
        nxt();
        rst_n = 1'b1; #1;
        chk("mrst_run", 32'(outs), 32'(O_RUN));
        nxt();
        chk("mrst_cnt_after", 32'(stall_cnt), 0);
        l1d_val = 1; #1;
        nxt();
        chk("mrst_wait_clr", 32'(err), 0);
        chk("mrst_dmiss", 32'(outs), 32'(O_DMS));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
